// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the mini CPU control sequencer: opcodes, FSM
// states, ALU operation codes and error codes, plus small opcode helpers.
package cpu_ctrl_seq_pkg;

    // Opcode field values (IR[7:4]); 9..E are unassigned and illegal.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation select driven during EXEC.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Error codes reported while in ERR.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPER   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Two-operand ALU instructions: these take the OPER + EXEC path.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Instructions that need a second memory access with the operand address.
    function automatic logic needs_oper(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STA) || is_alu_op(op);
    endfunction

    // ALU select for an ALU opcode (ADD..OR map onto 00..11).
    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        logic [1:0] sel;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cpu_ctrl_seq_wait_timer.sv
// Memory wait timer for the control sequencer.
// Counts consecutive cycles a memory request is outstanding without an
// acknowledge and flags expiry on the cycle the count would reach MAX_WAIT.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  return the count to zero (priority over count)
//   count   in  one more cycle of waiting (request high, no ack)
//   expire  out this waiting cycle is the MAX_WAIT-th one; give up
module cpu_ctrl_seq_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (clear) begin
            cnt_reg <= 8'd0;
        end else if (count) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    // cnt_reg holds the waits already seen; an ack in this same cycle
    // deasserts count and so always beats the timeout.
    assign expire = count && (cnt_reg == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit mini CPU.
// Walks FETCH -> DECODE -> (OPER -> (EXEC)) for the instruction in IR and
// drives register load enables, PC strobes, ALU select and the memory
// request handshake. HLT, illegal opcodes and bus timeouts are absorbing.
// Ports:
//   CLK, CLRn          clock, asynchronous active-low reset
//   Start              leave IDLE and start fetching
//   IR_Q               instruction register {opcode, operand}
//   Zero               registered zero flag (used by JZ)
//   Mem_Ack            memory completes the current request
//   Mem_Req, Mem_We    memory request / write qualifier
//   Addr_Sel           0 = PC address, 1 = IR operand address
//   IR_En, A_En, A_Src, B_En, Flag_En   datapath load enables / A source
//   ALU_Op             ALU operation select
//   PC_Inc, PC_Load    program counter strobes (mutually exclusive)
//   Halted, Err, Err_Code   terminal status
module cpu_ctrl_seq
    import cpu_ctrl_seq_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic          CLK,
    input  logic          CLRn,
    input  logic          Start,
    input  logic [DW-1:0] IR_Q,
    input  logic          Zero,
    input  logic          Mem_Ack,
    output logic          Mem_Req,
    output logic          Mem_We,
    output logic          Addr_Sel,
    output logic          IR_En,
    output logic          A_En,
    output logic          A_Src,
    output logic          B_En,
    output logic          Flag_En,
    output logic [1:0]    ALU_Op,
    output logic          PC_Inc,
    output logic          PC_Load,
    output logic          Halted,
    output logic          Err,
    output logic [1:0]    Err_Code
);

    state_t     state_reg, state_next;
    logic [1:0] err_code_reg, err_code_next;
    logic [3:0] opcode;
    logic       unused_operand;
    logic       wait_clear, wait_count, wait_expire;

    assign opcode = IR_Q[DW-1 -: 4];
    // The operand field feeds the address mux in the datapath, not this block.
    assign unused_operand = ^IR_Q[AW-1:0];

    // Any cycle without an outstanding, unacknowledged request resets the
    // count, which also covers every entry into FETCH and OPER.
    assign wait_count = Mem_Req && !Mem_Ack;
    assign wait_clear = !wait_count;

    cpu_ctrl_seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (CLK),
        .rst_n  (CLRn),
        .clear  (wait_clear),
        .count  (wait_count),
        .expire (wait_expire)
    );

    // State register
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_reg    <= ST_IDLE;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (Mem_Ack) begin
                    state_next = ST_DECODE;
                end else if (wait_expire) begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_NOP || opcode == OP_JMP || opcode == OP_JZ) begin
                    state_next = ST_FETCH;
                end else if (needs_oper(opcode)) begin
                    state_next = ST_OPER;
                end else if (opcode == OP_HLT) begin
                    state_next = ST_HALT;
                end else begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_ILLEGAL;
                end
            end
            ST_OPER: begin
                if (Mem_Ack) begin
                    state_next = is_alu_op(opcode) ? ST_EXEC : ST_FETCH;
                end else if (wait_expire) begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            ST_EXEC:  state_next = ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            ST_ERR:   state_next = ST_ERR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        Mem_Req  = 1'b0;
        Mem_We   = 1'b0;
        Addr_Sel = 1'b0;
        IR_En    = 1'b0;
        A_En     = 1'b0;
        A_Src    = 1'b0;
        B_En     = 1'b0;
        Flag_En  = 1'b0;
        ALU_Op   = ALU_ADD;
        PC_Inc   = 1'b0;
        PC_Load  = 1'b0;
        Halted   = 1'b0;
        Err      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                Mem_Req = 1'b1;
                IR_En   = Mem_Ack;
            end
            ST_DECODE: begin
                if (opcode == OP_JMP) begin
                    PC_Load = 1'b1;
                end else if (opcode == OP_JZ) begin
                    PC_Load = Zero;
                    PC_Inc  = !Zero;
                end else if (opcode == OP_NOP || needs_oper(opcode)) begin
                    PC_Inc = 1'b1;
                end
            end
            ST_OPER: begin
                Mem_Req  = 1'b1;
                Addr_Sel = 1'b1;
                Mem_We   = (opcode == OP_STA);
                if (Mem_Ack) begin
                    if (opcode == OP_LDA) begin
                        A_En    = 1'b1;
                        Flag_En = 1'b1;
                    end
                    B_En = is_alu_op(opcode);
                end
            end
            ST_EXEC: begin
                A_En    = 1'b1;
                A_Src   = 1'b1;
                Flag_En = 1'b1;
                ALU_Op  = alu_sel(opcode);
            end
            ST_HALT: Halted = 1'b1;
            ST_ERR:  Err    = 1'b1;
            default: ;
        endcase
    end

    assign Err_Code = err_code_reg;

endmodule
